// File: rtl/i2c_reg_pkg.sv
// ----------------------------------------------------------------------------
// i2c_reg_pkg
// Shared definitions for the single-register I2C sequencers (i2c_read_reg and
// i2c_write_reg), which sit side by side on one I2C master and one timeout
// timer.
//   - FSM state encodings (also exported on state_out for debug)
//   - default timeout select driven on timer_param
//   - command flag bundle type
//   - bus predicates: "bus valid" (ready to start a transfer) and
//     "bus free" (master has released the bus)
// ----------------------------------------------------------------------------
package i2c_reg_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_VALIDATE  = 4'd1;
    localparam logic [3:0] S_CMD_WR    = 4'd2;
    localparam logic [3:0] S_ADDR_BYTE = 4'd3;
    localparam logic [3:0] S_CMD_RD    = 4'd4;
    localparam logic [3:0] S_DATA_IN   = 4'd5;
    localparam logic [3:0] S_FREE      = 4'd6;
    localparam logic [3:0] S_MID_FREE  = 4'd7;

    localparam logic [3:0] TIMER_PARAM_DEFAULT = 4'b0001;

    // Command flags in the order the master's command port lists them.
    typedef struct packed {
        logic start;
        logic read;
        logic write_multiple;
        logic stop;
    } i2c_cmd_flags_t;

    localparam i2c_cmd_flags_t CMD_FLAGS_NONE = 4'b0000;

    // No transfer in flight and the master is not holding the bus.
    function automatic logic bus_valid(input logic bus_busy, input logic bus_active);
        return ~bus_busy & ~bus_active;
    endfunction

    // Master has finished and released bus control (STOP has gone out).
    function automatic logic bus_free(input logic bus_busy, input logic bus_control);
        return ~bus_busy & ~bus_control;
    endfunction

endpackage

// File: rtl/i2c_read_reg.sv
// ----------------------------------------------------------------------------
// i2c_read_reg
// Single-register I2C read sequencer. On a start pulse in idle it latches the
// device and register address, waits for the bus, writes the register pointer
// to the device, re-addresses it for a one-byte read, captures the byte into
// `data`, waits for the bus to be released and pulses `done`. A timeout or a
// missed ACK aborts with a one-cycle `message_failure` pulse.
//
// Build option:
//   I2C_READ_REG_REPSTART_EN  defined   : pointer write has stop=0 and the read
//                                         command follows with a repeated start.
//                             undefined : pointer write has stop=1 and the FSM
//                                         waits in S_MID_FREE for the bus to be
//                                         released before the read command.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   dev_address, reg_address request addresses, sampled with start
//   start                    one-cycle request, honoured only in S_IDLE
//   data, done,              read byte (held), completion pulse,
//   message_failure          failure pulse
//   timer_*                  external timeout timer control / expiry
//   i2c_cmd_*                command stream to the I2C master
//   i2c_data_out_*           write stream to the master
//   i2c_data_in_*            read stream from the master
//   i2c_bus_*, i2c_missed_ack master status
//   state_out                current FSM state for debug
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module i2c_read_reg
    import i2c_reg_pkg::*;
#(
    parameter logic [3:0] TIMEOUT_PARAM = TIMER_PARAM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] dev_address,
    input  logic [7:0] reg_address,
    input  logic       start,
    output logic [7:0] data,
    output logic       done,
    output logic       message_failure,
    input  logic       timer_exp,
    output logic       timer_start,
    output logic       timer_reset,
    output logic [3:0] timer_param,
    output logic [6:0] i2c_cmd_address,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_read,
    output logic       i2c_cmd_write_multiple,
    output logic       i2c_cmd_stop,
    output logic       i2c_cmd_valid,
    input  logic       i2c_cmd_ready,
    output logic [7:0] i2c_data_out,
    output logic       i2c_data_out_valid,
    input  logic       i2c_data_out_ready,
    output logic       i2c_data_out_last,
    input  logic [7:0] i2c_data_in,
    input  logic       i2c_data_in_valid,
    output logic       i2c_data_in_ready,
    input  logic       i2c_data_in_last,
    input  logic       i2c_bus_busy,
    input  logic       i2c_bus_control,
    input  logic       i2c_bus_active,
    input  logic       i2c_missed_ack,
    output logic [3:0] state_out
);

`ifdef I2C_READ_REG_REPSTART_EN
    localparam logic WR_CMD_STOP = 1'b0;
`else
    localparam logic WR_CMD_STOP = 1'b1;
`endif

    localparam i2c_cmd_flags_t WR_CMD_FLAGS = '{start: 1'b1, read: 1'b0,
                                                write_multiple: 1'b1, stop: WR_CMD_STOP};
    localparam i2c_cmd_flags_t RD_CMD_FLAGS = '{start: 1'b1, read: 1'b1,
                                                write_multiple: 1'b0, stop: 1'b1};

    logic [3:0]     state_q,          state_d;
    logic [6:0]     dev_addr_q,       dev_addr_d;
    logic [7:0]     reg_addr_q,       reg_addr_d;
    logic [7:0]     data_q,           data_d;
    logic           done_q,           done_d;
    logic           fail_q,           fail_d;
    logic           timer_start_q,    timer_start_d;
    logic           timer_reset_q,    timer_reset_d;
    logic [3:0]     timer_param_q,    timer_param_d;
    logic [6:0]     cmd_address_q,    cmd_address_d;
    i2c_cmd_flags_t cmd_flags_q,      cmd_flags_d;
    logic           cmd_valid_q,      cmd_valid_d;
    logic [7:0]     data_out_q,       data_out_d;
    logic           data_out_valid_q, data_out_valid_d;
    logic           data_out_last_q,  data_out_last_d;
    logic           data_in_ready_q,  data_in_ready_d;

    logic cmd_xfer;
    logic wr_xfer;
    logic rd_xfer;
    logic unused_inputs;

    assign cmd_xfer = cmd_valid_q & i2c_cmd_ready;
    assign wr_xfer  = data_out_valid_q & i2c_data_out_ready;
    assign rd_xfer  = data_in_ready_q & i2c_data_in_valid;

    // A short final read is still a complete one-byte read, so the last flag
    // carries no information here.
    assign unused_inputs = i2c_data_in_last;

    // Next-state and next-output logic of the read sequencer.
    always_comb begin
        state_d          = state_q;
        dev_addr_d       = dev_addr_q;
        reg_addr_d       = reg_addr_q;
        data_d           = data_q;
        done_d           = 1'b0;
        fail_d           = 1'b0;
        timer_start_d    = 1'b0;
        timer_reset_d    = timer_reset_q;
        timer_param_d    = TIMEOUT_PARAM;
        cmd_address_d    = cmd_address_q;
        cmd_flags_d      = cmd_flags_q;
        cmd_valid_d      = cmd_valid_q;
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;
        data_out_last_d  = data_out_last_q;
        data_in_ready_d  = data_in_ready_q;

        // Every non-idle state is a timed wait; a missed ACK or an expired
        // timer abandons the transaction from wherever it is. Neither can
        // coincide with done, since both suppress the normal transitions.
        if ((state_q != S_IDLE) && (i2c_missed_ack || timer_exp)) begin
            state_d          = S_IDLE;
            fail_d           = 1'b1;
            timer_reset_d    = 1'b1;
            cmd_flags_d      = CMD_FLAGS_NONE;
            cmd_valid_d      = 1'b0;
            data_out_valid_d = 1'b0;
            data_out_last_d  = 1'b0;
            data_in_ready_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dev_addr_d    = dev_address;
                        reg_addr_d    = reg_address;
                        state_d       = S_VALIDATE;
                        timer_start_d = 1'b1;
                        timer_reset_d = 1'b0;
                    end else begin
                        timer_reset_d = 1'b1;
                    end
                end

                S_VALIDATE: begin
                    if (bus_valid(i2c_bus_busy, i2c_bus_active)) begin
                        state_d       = S_CMD_WR;
                        timer_start_d = 1'b1;
                        cmd_address_d = dev_addr_q;
                        cmd_flags_d   = WR_CMD_FLAGS;
                        cmd_valid_d   = 1'b1;
                    end else begin
                        state_d = S_VALIDATE;
                    end
                end

                S_CMD_WR: begin
                    if (cmd_xfer) begin
                        state_d          = S_ADDR_BYTE;
                        timer_start_d    = 1'b1;
                        cmd_valid_d      = 1'b0;
                        data_out_d       = reg_addr_q;
                        data_out_valid_d = 1'b1;
                        data_out_last_d  = 1'b1;
                    end else begin
                        state_d = S_CMD_WR;
                    end
                end

                S_ADDR_BYTE: begin
                    if (wr_xfer) begin
                        timer_start_d    = 1'b1;
                        data_out_valid_d = 1'b0;
                        data_out_last_d  = 1'b0;
`ifdef I2C_READ_REG_REPSTART_EN
                        state_d          = S_CMD_RD;
                        cmd_address_d    = dev_addr_q;
                        cmd_flags_d      = RD_CMD_FLAGS;
                        cmd_valid_d      = 1'b1;
`else
                        state_d          = S_MID_FREE;
`endif
                    end else begin
                        state_d = S_ADDR_BYTE;
                    end
                end

                // Only reached when the pointer write ends with its own STOP.
                S_MID_FREE: begin
                    if (bus_free(i2c_bus_busy, i2c_bus_control)) begin
                        state_d       = S_CMD_RD;
                        timer_start_d = 1'b1;
                        cmd_address_d = dev_addr_q;
                        cmd_flags_d   = RD_CMD_FLAGS;
                        cmd_valid_d   = 1'b1;
                    end else begin
                        state_d = S_MID_FREE;
                    end
                end

                S_CMD_RD: begin
                    if (cmd_xfer) begin
                        state_d         = S_DATA_IN;
                        timer_start_d   = 1'b1;
                        cmd_valid_d     = 1'b0;
                        data_in_ready_d = 1'b1;
                    end else begin
                        state_d = S_CMD_RD;
                    end
                end

                S_DATA_IN: begin
                    if (rd_xfer) begin
                        state_d         = S_FREE;
                        timer_start_d   = 1'b1;
                        data_d          = i2c_data_in;
                        data_in_ready_d = 1'b0;
                    end else begin
                        state_d = S_DATA_IN;
                    end
                end

                // done is only reported once the master has let go of the bus,
                // so the sibling sequencer can be granted straight away.
                S_FREE: begin
                    if (bus_free(i2c_bus_busy, i2c_bus_control)) begin
                        state_d       = S_IDLE;
                        done_d        = 1'b1;
                        timer_reset_d = 1'b1;
                        cmd_flags_d   = CMD_FLAGS_NONE;
                    end else begin
                        state_d = S_FREE;
                    end
                end

                default: begin
                    state_d          = S_IDLE;
                    timer_reset_d    = 1'b1;
                    cmd_flags_d      = CMD_FLAGS_NONE;
                    cmd_valid_d      = 1'b0;
                    data_out_valid_d = 1'b0;
                    data_out_last_d  = 1'b0;
                    data_in_ready_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            dev_addr_q       <= 7'h00;
            reg_addr_q       <= 8'h00;
            data_q           <= 8'h00;
            done_q           <= 1'b0;
            fail_q           <= 1'b0;
            timer_start_q    <= 1'b0;
            timer_reset_q    <= 1'b1;
            timer_param_q    <= TIMEOUT_PARAM;
            cmd_address_q    <= 7'h00;
            cmd_flags_q      <= CMD_FLAGS_NONE;
            cmd_valid_q      <= 1'b0;
            data_out_q       <= 8'h00;
            data_out_valid_q <= 1'b0;
            data_out_last_q  <= 1'b0;
            data_in_ready_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            dev_addr_q       <= dev_addr_d;
            reg_addr_q       <= reg_addr_d;
            data_q           <= data_d;
            done_q           <= done_d;
            fail_q           <= fail_d;
            timer_start_q    <= timer_start_d;
            timer_reset_q    <= timer_reset_d;
            timer_param_q    <= timer_param_d;
            cmd_address_q    <= cmd_address_d;
            cmd_flags_q      <= cmd_flags_d;
            cmd_valid_q      <= cmd_valid_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_last_q  <= data_out_last_d;
            data_in_ready_q  <= data_in_ready_d;
        end
    end

    assign data                   = data_q;
    assign done                   = done_q;
    assign message_failure        = fail_q;
    assign timer_start            = timer_start_q;
    assign timer_reset            = timer_reset_q;
    assign timer_param            = timer_param_q;
    assign i2c_cmd_address        = cmd_address_q;
    assign i2c_cmd_start          = cmd_flags_q.start;
    assign i2c_cmd_read           = cmd_flags_q.read;
    assign i2c_cmd_write_multiple = cmd_flags_q.write_multiple;
    assign i2c_cmd_stop           = cmd_flags_q.stop;
    assign i2c_cmd_valid          = cmd_valid_q;
    assign i2c_data_out           = data_out_q;
    assign i2c_data_out_valid     = data_out_valid_q;
    assign i2c_data_out_last      = data_out_last_q;
    assign i2c_data_in_ready      = data_in_ready_q;
    assign state_out              = state_q;

endmodule

// File: tb/tb_i2c_read_reg.sv
// ----------------------------------------------------------------------------
// tb_i2c_read_reg
// Scoreboard bench for i2c_read_reg. Stimulus pushes the expected command,
// write-stream and completion records into queues; a monitor pops and checks
// them whenever the DUT transfers on a stream or reports done/failure. A slave
// process models the I2C master's readies and read data.
// ----------------------------------------------------------------------------
module tb_i2c_read_reg;

`ifdef I2C_READ_REG_REPSTART_EN
    localparam int   X       = 0;
    localparam logic STOP_WR = 1'b0;
`else
    localparam int   X       = 1;
    localparam logic STOP_WR = 1'b1;
`endif

    logic       clk;
    logic       reset;
    logic [6:0] dev_address;
    logic [7:0] reg_address;
    logic       start;
    logic [7:0] data;
    logic       done;
    logic       message_failure;
    logic       timer_exp;
    logic       timer_start;
    logic       timer_reset;
    logic [3:0] timer_param;
    logic [6:0] i2c_cmd_address;
    logic       i2c_cmd_start, i2c_cmd_read, i2c_cmd_write_multiple, i2c_cmd_stop;
    logic       i2c_cmd_valid, i2c_cmd_ready;
    logic [7:0] i2c_data_out;
    logic       i2c_data_out_valid, i2c_data_out_ready, i2c_data_out_last;
    logic [7:0] i2c_data_in;
    logic       i2c_data_in_valid, i2c_data_in_ready, i2c_data_in_last;
    logic       i2c_bus_busy, i2c_bus_control, i2c_bus_active, i2c_missed_ack;
    logic [3:0] state_out;

    i2c_read_reg dut (
        .clk(clk), .reset(reset),
        .dev_address(dev_address), .reg_address(reg_address), .start(start),
        .data(data), .done(done), .message_failure(message_failure),
        .timer_exp(timer_exp), .timer_start(timer_start), .timer_reset(timer_reset),
        .timer_param(timer_param),
        .i2c_cmd_address(i2c_cmd_address), .i2c_cmd_start(i2c_cmd_start),
        .i2c_cmd_read(i2c_cmd_read), .i2c_cmd_write_multiple(i2c_cmd_write_multiple),
        .i2c_cmd_stop(i2c_cmd_stop), .i2c_cmd_valid(i2c_cmd_valid),
        .i2c_cmd_ready(i2c_cmd_ready),
        .i2c_data_out(i2c_data_out), .i2c_data_out_valid(i2c_data_out_valid),
        .i2c_data_out_ready(i2c_data_out_ready), .i2c_data_out_last(i2c_data_out_last),
        .i2c_data_in(i2c_data_in), .i2c_data_in_valid(i2c_data_in_valid),
        .i2c_data_in_ready(i2c_data_in_ready), .i2c_data_in_last(i2c_data_in_last),
        .i2c_bus_busy(i2c_bus_busy), .i2c_bus_control(i2c_bus_control),
        .i2c_bus_active(i2c_bus_active), .i2c_missed_ack(i2c_missed_ack),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected records
    typedef struct packed { logic [6:0] addr; logic [3:0] flags; } exp_cmd_t;
    typedef struct packed { logic fail; logic [7:0] data; } exp_res_t;
    exp_cmd_t   exp_cmd_q[$];
    logic [7:0] exp_wr_q[$];
    exp_res_t   exp_res_q[$];
    logic [7:0] last_good;

    int n_tests = 0;
    int n_fail  = 0;

    // slave model controls
    logic       rand_rdy, rand_bus, resp_en, out_hold, force_busy;
    int         cmd_hold;
    logic [7:0] resp_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model of one successful read: pointer write, register byte,
    // read command, then done carrying the slave's byte.
    task automatic push_good(input logic [6:0] d, input logic [7:0] r, input logic [7:0] b);
        exp_cmd_q.push_back({d, 3'b101, STOP_WR});
        exp_wr_q.push_back(r);
        exp_cmd_q.push_back({d, 4'b1101});
        exp_res_q.push_back({1'b0, b});
        last_good = b;
    endtask

    task automatic do_start(input logic [6:0] d, input logic [7:0] r);
        tick();
        start = 1'b1; dev_address = d; reg_address = r;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && exp_res_q.size() != 0; i++) @(negedge clk);
        chk({name, "_complete"}, exp_res_q.size(), 0);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_ctl"}, {done, message_failure, timer_start, timer_reset, timer_param, state_out},
            {1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'h0});
        chk({name, "_bus"}, {i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_write_multiple,
                             i2c_cmd_stop, i2c_cmd_valid, i2c_data_out, i2c_data_out_valid,
                             i2c_data_out_last, i2c_data_in_ready}, 32'h0);
    endtask

    // Slave side: readies, read data and bus status, updated just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmd_hold > 0 && i2c_cmd_valid) begin
                i2c_cmd_ready = 1'b0;
                cmd_hold--;
            end else begin
                i2c_cmd_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            i2c_data_out_ready = out_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
            i2c_data_in_valid  = resp_en & (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
            i2c_data_in        = i2c_data_in_valid ? resp_byte : 8'($urandom);
            i2c_data_in_last   = 1'($urandom_range(0, 1));
            i2c_bus_busy       = force_busy | (rand_bus & ($urandom_range(0, 7) == 0));
            i2c_bus_active     = rand_bus & ($urandom_range(0, 7) == 0);
            i2c_bus_control    = rand_bus & ($urandom_range(0, 7) == 0);
        end
    end

    // Monitor / scoreboard.
    logic       stall_prev, prev_abort, prev_done, prev_fail;
    logic [10:0] prev_cmd, cur_cmd;
    exp_cmd_t   ec;
    exp_res_t   er;
    logic [7:0] ew;
    initial begin
        stall_prev = 1'b0; prev_abort = 1'b0; prev_done = 1'b0; prev_fail = 1'b0;
        prev_cmd = 11'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0; prev_done = 1'b0; prev_fail = 1'b0;
            end else begin
                cur_cmd = {i2c_cmd_address, i2c_cmd_start, i2c_cmd_read,
                           i2c_cmd_write_multiple, i2c_cmd_stop};
                if (stall_prev && !prev_abort) begin
                    chk("cmd_valid_held", i2c_cmd_valid, 1);
                    chk("cmd_stable", cur_cmd, prev_cmd);
                end
                if (i2c_cmd_valid && i2c_cmd_ready) begin
                    if (exp_cmd_q.size() == 0) chk("cmd_unexpected", exp_cmd_q.size(), 1);
                    else begin
                        ec = exp_cmd_q.pop_front();
                        chk("cmd_addr", i2c_cmd_address, ec.addr);
                        chk("cmd_flags", cur_cmd[3:0], ec.flags);
                    end
                end
                if (i2c_data_out_valid && i2c_data_out_ready) begin
                    if (exp_wr_q.size() == 0) chk("wr_unexpected", exp_wr_q.size(), 1);
                    else begin
                        ew = exp_wr_q.pop_front();
                        chk("wr_byte", i2c_data_out, ew);
                        chk("wr_last", i2c_data_out_last, 1);
                    end
                end
                if (done || message_failure) begin
                    chk("done_fail_exclusive", done & message_failure, 0);
                    chk("pulse_width", {prev_done & done, prev_fail & message_failure}, 0);
                    if (exp_res_q.size() == 0) chk("result_unexpected", exp_res_q.size(), 1);
                    else begin
                        er = exp_res_q.pop_front();
                        chk("result_failure", message_failure, er.fail);
                        chk("result_data", data, er.data);
                    end
                end
                stall_prev = i2c_cmd_valid & ~i2c_cmd_ready;
                prev_cmd   = cur_cmd;
                prev_abort = i2c_missed_ack | timer_exp;
                prev_done  = done;
                prev_fail  = message_failure;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [6:0] rd;
    logic [7:0] rr, rb;

    initial begin
        reset = 1'b1; start = 1'b0; dev_address = 7'h00; reg_address = 8'h00;
        timer_exp = 1'b0; i2c_missed_ack = 1'b0;
        i2c_cmd_ready = 1'b0; i2c_data_out_ready = 1'b0; i2c_data_in_valid = 1'b0;
        i2c_data_in = 8'h00; i2c_data_in_last = 1'b0;
        i2c_bus_busy = 1'b0; i2c_bus_active = 1'b0; i2c_bus_control = 1'b0;
        rand_rdy = 1'b0; rand_bus = 1'b0; resp_en = 1'b0; out_hold = 1'b0;
        force_busy = 1'b0; cmd_hold = 0; resp_byte = 8'h00; last_good = 8'h00;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset("por");
        chk("por_data", data, 8'h00);

        // T1: basic read with latency table
        resp_en = 1'b1; resp_byte = 8'h48;
        push_good(7'h1E, 8'h0A, 8'h48);
        tick();
        start = 1'b1; dev_address = 7'h1E; reg_address = 8'h0A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t1_c%0d_cmd_valid", k), i2c_cmd_valid, (k == 2) || (k == 4 + X));
            chk($sformatf("t1_c%0d_out_valid", k), i2c_data_out_valid, k == 3);
            chk($sformatf("t1_c%0d_in_ready", k), i2c_data_in_ready, k == 5 + X);
            chk($sformatf("t1_c%0d_done", k), done, k == 7 + X);
            chk($sformatf("t1_c%0d_timer_start", k), timer_start, (k >= 1) && (k <= 6 + X));
            chk($sformatf("t1_c%0d_timer_reset", k), timer_reset, !((k >= 1) && (k <= 6 + X)));
            tick();
            start = 1'b0;
        end
        wait_idle("t1", 10);

        // T2: command ready held low for 5 cycles
        cmd_hold = 5; resp_byte = 8'hE7;
        push_good(7'h33, 8'h91, 8'hE7);
        do_start(7'h33, 8'h91);
        wait_idle("t2", 100);
        chk("t2_hold_consumed", cmd_hold, 0);

        // T3: read data never arrives, timer expires
        resp_en = 1'b0;
        exp_cmd_q.push_back({7'h52, 3'b101, STOP_WR});
        exp_wr_q.push_back(8'h10);
        exp_cmd_q.push_back({7'h52, 4'b1101});
        exp_res_q.push_back({1'b1, last_good});
        do_start(7'h52, 8'h10);
        for (int i = 0; i < 50 && !i2c_data_in_ready; i++) @(negedge clk);
        chk("t3_reach_data_in", i2c_data_in_ready, 1);
        repeat (20) tick();
        timer_exp = 1'b1;
        tick();
        timer_exp = 1'b0;
        wait_idle("t3", 10);
        @(negedge clk);
        chk("t3_state_idle", state_out, 4'h0);
        chk("t3_data_kept", data, 8'hE7);

        // T4: missed ACK while the register byte is pending
        out_hold = 1'b1; resp_en = 1'b1;
        exp_cmd_q.push_back({7'h0C, 3'b101, STOP_WR});
        exp_res_q.push_back({1'b1, last_good});
        do_start(7'h0C, 8'h22);
        for (int i = 0; i < 50 && !i2c_data_out_valid; i++) @(negedge clk);
        chk("t4_reach_addr_byte", i2c_data_out_valid, 1);
        tick();
        i2c_missed_ack = 1'b1;
        tick();
        i2c_missed_ack = 1'b0;
        @(negedge clk);
        chk("t4_fail_pulse", {message_failure, done}, 2'b10);
        chk("t4_valids_clear", {i2c_cmd_valid, i2c_data_out_valid, i2c_data_in_ready}, 3'b000);
        chk("t4_state_idle", state_out, 4'h0);
        out_hold = 1'b0;
        wait_idle("t4", 10);

        // T5: reset while waiting for read data, then a clean read
        resp_en = 1'b0;
        exp_cmd_q.push_back({7'h41, 3'b101, STOP_WR});
        exp_wr_q.push_back(8'h07);
        exp_cmd_q.push_back({7'h41, 4'b1101});
        do_start(7'h41, 8'h07);
        for (int i = 0; i < 50 && !i2c_data_in_ready; i++) @(negedge clk);
        chk("t5_reach_data_in", i2c_data_in_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_reset("t5_mid");
        tick();
        reset = 1'b0;
        chk("t5_no_stale_exp", exp_cmd_q.size() + exp_wr_q.size(), 0);
        resp_en = 1'b1; resp_byte = 8'h5A;
        push_good(7'h41, 8'h07, 8'h5A);
        do_start(7'h41, 8'h07);
        wait_idle("t5", 60);

`ifndef I2C_READ_REG_REPSTART_EN
        // T6: bus stays busy between pointer write and read command
        resp_byte = 8'hC3;
        push_good(7'h2A, 8'h5C, 8'hC3);
        do_start(7'h2A, 8'h5C);
        for (int i = 0; i < 50 && !i2c_data_out_valid; i++) @(negedge clk);
        chk("t6_reach_addr_byte", i2c_data_out_valid, 1);
        force_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t6_busy%0d_no_rd_cmd", i), i2c_cmd_valid, 0);
        end
        force_busy = 1'b0;
        wait_idle("t6", 30);
`endif

        // Random phase: random addresses, data, readies and bus status;
        // late address changes and a spurious start must be ignored.
        rand_rdy = 1'b1; rand_bus = 1'b1; resp_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            rd = 7'($urandom); rr = 8'($urandom); rb = 8'($urandom);
            resp_byte = rb;
            push_good(rd, rr, rb);
            tick();
            start = 1'b1; dev_address = rd; reg_address = rr;
            tick();
            start = 1'b0; dev_address = 7'($urandom); reg_address = 8'($urandom);
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_idle($sformatf("rand%0d", n), 400);
        end
        rand_rdy = 1'b0; rand_bus = 1'b0;
        repeat (3) tick();
        chk("end_cmd_q_empty", exp_cmd_q.size(), 0);
        chk("end_wr_q_empty", exp_wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
